// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock by trial
// subtraction, with valid/ready handshakes on the operand and result sides.
module seq_divider #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  q_r;
  logic [N-1:0]  div_r;
  logic [N:0]    p_r;
  logic [CW-1:0] cnt;
  logic          dbz_r;

  logic          accept;
  logic          xfer;
  logic          last_step;
  logic [N:0]    p_shift;
  logic [N+1:0]  sub_res;
  logic          no_borrow;

  // P + ~{0,d} + 1 in N+1 bits; bit N+1 of the result is the carry-out.
  function automatic logic [N+1:0] trial_sub(input logic [N:0] p, input logic [N-1:0] d);
    trial_sub = {1'b0, p} + {1'b0, ~{1'b0, d}} + {{(N+1){1'b0}}, 1'b1};
  endfunction

  assign accept    = in_valid && (state == IDLE);
  assign xfer      = out_ready && (state == DONE);
  assign last_step = (cnt == CW'(N - 1));
  assign p_shift   = {p_r[N-1:0], q_r[N-1]};
  assign sub_res   = trial_sub(p_shift, div_r);
  assign no_borrow = sub_res[N+1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (divisor == '0) ? DONE : CALC;
      CALC: if (last_step) state_nxt = DONE;
      DONE: if (xfer) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A zero divisor skips the iteration and presents the saturated result at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r   <= '0;
      p_r   <= '0;
      div_r <= '0;
      cnt   <= '0;
      dbz_r <= 1'b0;
    end else if (accept) begin
      div_r <= divisor;
      cnt   <= '0;
      if (divisor == '0) begin
        q_r   <= '1;
        p_r   <= {1'b0, dividend};
        dbz_r <= 1'b1;
      end else begin
        q_r   <= dividend;
        p_r   <= '0;
      end
    end else if (state == CALC) begin
      q_r <= {q_r[N-2:0], no_borrow};
      p_r <= no_borrow ? sub_res[N:0] : p_shift;
      cnt <= cnt + 1'b1;
    end else if (xfer) begin
      dbz_r <= 1'b0;
    end
  end

  assign in_ready    = (state == IDLE);
  assign out_valid   = (state == DONE);
  assign quotient    = q_r;
  assign remainder   = p_r[N-1:0];
  assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: directed boundary cases plus a randomised
// regression against a plain-arithmetic reference model.
module tb_seq_divider;

  localparam int N = 16;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  seq_divider #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dbz;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  bit   rand_mode = 0;
  logic ready_fixed = 1'b1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer division with the zero-divisor convention.
  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b);
    exp_t e;
    e.a = a;
    e.b = b;
    if (b == 0) begin
      e.q = {N{1'b1}};
      e.r = a;
      e.dbz = 1'b1;
    end else begin
      e.q = a / b;
      e.r = a % b;
      e.dbz = 1'b0;
    end
    return e;
  endfunction

  // out_ready driver: fixed value in directed tests, random in regression.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      out_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_fixed;
    end
  end

  // Monitor: one pop per result transfer.
  initial begin
    exp_t e;
    longint prod;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", 64'(quotient), 64'hDEAD);
        end else begin
          e = sb.pop_front();
          chk("quotient", 64'(quotient), 64'(e.q));
          chk("remainder", 64'(remainder), 64'(e.r));
          chk("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
          if (e.b != 0) begin
            prod = longint'(quotient) * longint'(e.b) + longint'(remainder);
            chk("invariant_qd_plus_r", 64'(prod), 64'(e.a));
            chk("invariant_r_lt_d", 64'(remainder < e.b), 64'd1);
          end
        end
      end
    end
  end

  task automatic send(input logic [N-1:0] a, input logic [N-1:0] b);
    int k = 0;
    @(negedge clk);
    while (!in_ready && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) chk("in_ready_timeout", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    sb.push_back(model(a, b));
  endtask

  task automatic wait_valid(input string name, input int exp_edges);
    int k = 0;
    while (!out_valid && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk(name, 64'(k), 64'(exp_edges));
  endtask

  task automatic wait_idle();
    int k = 0;
    while (out_valid && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("result_taken", 64'(out_valid), 64'd0);
  endtask

  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b);
    send(a, b);
    wait_valid("latency", (b == 0) ? 0 : N);
    wait_idle();
  endtask

  initial begin
    logic [N-1:0] a, b;
    int k;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    dividend = '0;
    divisor  = '0;
    #12;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_quotient", 64'(quotient), 64'd0);
    chk("rst_remainder", 64'(remainder), 64'd0);
    chk("rst_dbz", 64'(div_by_zero), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(16'd100, 16'd7);
    do_op(16'hFFFF, 16'h0001);
    do_op(16'h8000, 16'hFFFF);
    do_op(16'd5, 16'd0);
    do_op(16'd42, 16'd5);
    do_op(16'd0, 16'd9);
    do_op(16'd12, 16'd12);

    // Back-pressure: result held with out_ready low, stray in_valid ignored.
    ready_fixed = 1'b0;
    @(posedge clk);
    #3;
    send(16'd3, 16'd10);
    wait_valid("bp_latency", N);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_quotient", 64'(quotient), 64'd0);
      chk("bp_remainder", 64'(remainder), 64'd3);
      if (i == 2) begin
        in_valid = 1'b1;
        dividend = 16'd77;
        divisor  = 16'd1;
      end else if (i == 3) begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    ready_fixed = 1'b1;
    @(posedge clk);
    #3;
    chk("bp_hold_quotient", 64'(quotient), 64'd0);
    chk("bp_hold_remainder", 64'(remainder), 64'd3);
    @(posedge clk);
    #1;
    chk("bp_in_ready_after", 64'(in_ready), 64'd1);
    chk("bp_out_valid_after", 64'(out_valid), 64'd0);

    // Reset in the middle of an iteration discards the result.
    send(16'd1000, 16'd3);
    repeat (8) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_quotient", 64'(quotient), 64'd0);
    chk("midrst_remainder", 64'(remainder), 64'd0);
    chk("midrst_dbz", 64'(div_by_zero), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(16'd9, 16'd4);

    // Randomised regression with random back-pressure.
    rand_mode = 1;
    for (int i = 0; i < 1000; i++) begin
      a = 16'($urandom);
      b = 16'($urandom_range(1, 16'hFFFF) >> $urandom_range(0, 15));
      if (b == 0) b = 16'd1;
      send(a, b);
    end
    k = 0;
    while ((sb.size() != 0) && k < 2000) begin
      @(posedge clk);
      k++;
    end
    chk("drain", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
